// File: rtl/pipe_sel_stage_if.sv
// Handshake bundle for pipe_sel_stage: upstream offer, downstream drain and status.
// The master modport drives the stage, the slave modport is the stage itself.
interface pipe_sel_stage_if #(
  parameter int WIDTH = 32,
  parameter int NSEL  = 4,
  parameter int SELW  = 2
);
  logic [NSEL*WIDTH-1:0] in_data;
  logic [SELW-1:0]       in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;
  logic [1:0]            occupancy;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, sel_err, occupancy
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, sel_err, occupancy
  );
endinterface

// File: rtl/pipe_sel_stage.sv
// NSEL:1 operand selector registered into a 2-entry skid stage with a valid/ready handshake,
// synchronous flush and a sticky out-of-range select flag.
module pipe_sel_stage #(
  parameter int WIDTH = 32,
  parameter int NSEL  = 4,
  parameter int SELW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_sel_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [1:0]       occ_q;
  logic             sel_err_q;

  logic [WIDTH-1:0] sel_val_d;
  logic             sel_oob;
  logic             accept;
  logic             out_fire;

  // NOTE: every variable written here gets a default first, otherwise a path
  // that does not assign it would infer a latch.
  always_comb begin
    sel_val_d = '0;
    for (int k = 0; k < NSEL; k++) begin
      if (bus.in_sel == SELW'(k)) sel_val_d = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  assign sel_oob  = (int'(bus.in_sel) >= NSEL);
  assign accept   = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the two data registers are reset too so out_data
  // reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
      sel_err_q   <= 1'b0;
    end else if (bus.flush) begin
      // Held beats and any beat offered on this edge are dropped; data and sel_err are kept.
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      if (accept && sel_oob) sel_err_q <= 1'b1;
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_q      <= sel_val_d;
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
            occ_q       <= 2'd1;
          end
        end
        S_ONE: begin
          if (accept && out_fire) begin
            main_q <= sel_val_d;
          end else if (accept) begin
            skid_q     <= sel_val_d;
            state_q    <= S_FULL;
            in_ready_q <= 1'b0;
            occ_q      <= 2'd2;
          end else if (out_fire) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            main_q     <= skid_q;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd1;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

  assign bus.out_data  = main_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.occupancy = occ_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_pipe_sel_stage.sv
// Bench for pipe_sel_stage: an NSEL=4 and an NSEL=3 instance share one stimulus stream and
// are compared every cycle against a queue-based model of the stage.
module tb_pipe_sel_stage;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4*W-1:0] src;
  logic [1:0]     sel;
  logic           vld, rdy, fl;

  pipe_sel_stage_if #(.WIDTH(W), .NSEL(4), .SELW(2)) if_a ();
  pipe_sel_stage_if #(.WIDTH(W), .NSEL(3), .SELW(2)) if_b ();

  assign if_a.in_data   = src;
  assign if_a.in_sel    = sel;
  assign if_a.in_valid  = vld;
  assign if_a.flush     = fl;
  assign if_a.out_ready = rdy;
  assign if_b.in_data   = src[3*W-1:0];
  assign if_b.in_sel    = sel;
  assign if_b.in_valid  = vld;
  assign if_b.flush     = fl;
  assign if_b.out_ready = rdy;

  pipe_sel_stage #(.WIDTH(W), .NSEL(4), .SELW(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  pipe_sel_stage #(.WIDTH(W), .NSEL(3), .SELW(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  int checks = 0;
  int failures = 0;

  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  logic [W-1:0] last_a, last_b;
  bit           err_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pick(input int nsel, input logic [1:0] s, input logic [4*W-1:0] d);
    if (int'(s) < nsel) return d[int'(s)*W +: W];
    return '0;
  endfunction

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    last_a = '0;
    last_b = '0;
    err_b  = 1'b0;
  endtask

  // Called just after a rising edge; inputs still hold their pre-edge values.
  task automatic model_edge();
    bit fire, acc;
    fire = (q_a.size() > 0) && rdy;
    acc  = vld && (q_a.size() < 2);
    if (fl) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (fire) begin
        void'(q_a.pop_front());
        void'(q_b.pop_front());
      end
      if (acc) begin
        q_a.push_back(pick(4, sel, src));
        q_b.push_back(pick(3, sel, src));
        if (int'(sel) >= 3) err_b = 1'b1;
      end
    end
    if (q_a.size() > 0) last_a = q_a[0];
    if (q_b.size() > 0) last_b = q_b[0];
  endtask

  task automatic check_all(input string tag);
    check({tag, "_a_valid"}, 32'(if_a.out_valid), 32'(q_a.size() > 0));
    check({tag, "_a_data"},  if_a.out_data,       last_a);
    check({tag, "_a_ready"}, 32'(if_a.in_ready),  32'(q_a.size() != 2));
    check({tag, "_a_occ"},   32'(if_a.occupancy), 32'(q_a.size()));
    check({tag, "_a_err"},   32'(if_a.sel_err),   32'd0);
    check({tag, "_b_valid"}, 32'(if_b.out_valid), 32'(q_b.size() > 0));
    check({tag, "_b_data"},  if_b.out_data,       last_b);
    check({tag, "_b_ready"}, 32'(if_b.in_ready),  32'(q_b.size() != 2));
    check({tag, "_b_occ"},   32'(if_b.occupancy), 32'(q_b.size()));
    check({tag, "_b_err"},   32'(if_b.sel_err),   32'(err_b));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    src = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    sel = 2'd0; vld = 1'b0; rdy = 1'b1; fl = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    check("reset_in_ready", 32'(if_a.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic select with 1-cycle latency.
    sel = 2'd2; vld = 1'b1;
    step("basic");
    check("basic_data", if_a.out_data, 32'h33333333);
    check("basic_occ", 32'(if_a.occupancy), 32'd1);
    vld = 1'b0;
    step("basic_drain");

    // Backpressure into the skid entry; sel=3 is out of range for the NSEL=3 instance.
    rdy = 1'b0; vld = 1'b1; sel = 2'd0;
    step("bp0");
    sel = 2'd3;
    step("bp1");
    check("bp_full_occ", 32'(if_a.occupancy), 32'd2);
    check("bp_full_ready", 32'(if_a.in_ready), 32'd0);
    check("bp_first", if_a.out_data, 32'h11111111);
    vld = 1'b0; rdy = 1'b1;
    step("bp_drain0");
    check("bp_second", if_a.out_data, 32'h44444444);
    check("oob_data", if_b.out_data, 32'h0);
    check("oob_err", 32'(if_b.sel_err), 32'd1);
    step("bp_drain1");
    check("bp_empty", 32'(if_a.out_valid), 32'd0);

    // Streaming: one beat per cycle, no bubbles.
    vld = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 2'(i % 4);
      step("stream");
      check("stream_data", if_a.out_data, 32'h11111111 * 32'((i % 4) + 1));
      check("stream_occ", 32'(if_a.occupancy), 32'd1);
    end
    vld = 1'b0;
    step("stream_drain");

    // Flush from FULL with a beat offered on the flush edge.
    rdy = 1'b0; vld = 1'b1; sel = 2'd1;
    step("fl0");
    sel = 2'd2;
    step("fl1");
    fl = 1'b1; sel = 2'd0;
    step("flush");
    check("flush_occ", 32'(if_a.occupancy), 32'd0);
    check("flush_valid", 32'(if_a.out_valid), 32'd0);
    check("flush_ready", 32'(if_a.in_ready), 32'd1);
    fl = 1'b0; vld = 1'b0; rdy = 1'b1;
    step("post_flush0");
    step("post_flush1");
    check("flush_dropped", 32'(if_a.out_valid), 32'd0);
    check("err_sticky", 32'(if_b.sel_err), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      src = {$urandom, $urandom, $urandom, $urandom};
      sel = 2'($urandom_range(0, 3));
      vld = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      step("rand");
    end
    fl = 1'b0;

    // Asynchronous reset pulse while FULL, entirely between clock edges.
    rdy = 1'b0; vld = 1'b1; sel = 2'd3;
    step("ar0");
    step("ar1");
    check("ar_full", 32'(if_a.occupancy), 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst_n = 1'b1;
    vld = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 3; i++) step("after_rst");
    check("ar_err_clear", 32'(if_b.sel_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
